knn_seq: RTL

Sequencer for the KNN datapath (distance core + sorted neighbour list).
- Holds up to 2^ADDR_W training points in an internal RAM, loaded over a simple write port.
- For each accepted test point it clears the neighbour list, streams every training point with its label into the datapath, waits for the last list update, then presents the neighbour-label vector on a valid/ready result port.
- Sits between the system CPU interface and the distance/list datapath, replacing the minimal load FSM.

---
 rtl/knn_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/knn_seq.sv
// knn_seq: sequencer for the KNN datapath (distance core + sorted neighbour list).
// Holds up to 2^ADDR_W labelled training points in an internal RAM. For each
// accepted test point it clears the list, streams every training point and its
// label to the datapath, waits for the last insert to settle, then presents the
// neighbour-label vector on a valid/ready result port.
// Optional build macro KNN_SEQ_PERF_EN adds a 32-bit per-run cycle counter
// (perf_cycles).
module knn_seq #(
  parameter int DATA_W      = 32,
  parameter int LABEL_W     = 8,
  parameter int N_NEIGHBOUR = 10,
  parameter int ADDR_W      = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W:0]                cfg_n_train,
  input  logic                           train_we,
  input  logic [ADDR_W-1:0]              train_addr,
  input  logic [DATA_W-1:0]              train_data,
  input  logic [LABEL_W-1:0]             train_label,
  input  logic                           test_valid,
  output logic                           test_ready,
  input  logic [DATA_W-1:0]              test_data,
  output logic [DATA_W-1:0]              dp_a,
  output logic [DATA_W-1:0]              dp_b,
  output logic [LABEL_W-1:0]             dp_label,
  output logic                           dp_valid,
  output logic                           dp_start,
  input  logic [LABEL_W*N_NEIGHBOUR-1:0] dp_info,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [LABEL_W*N_NEIGHBOUR-1:0] res_info,
  output logic                           busy,
  output logic                           err
`ifdef KNN_SEQ_PERF_EN
  ,
  output logic [31:0]                    perf_cycles
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  // Full capacity expressed in the width of the point count.
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Label and point stored side by side so one read returns a full candidate.
  logic [LABEL_W+DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W:0] n_q;      // points in this run, already clamped to capacity
  logic [ADDR_W:0] rd_addr;  // one bit wider than the RAM address: never wraps
  logic            accept;
  logic            last_addr;

  assign accept    = test_valid && (state == S_IDLE);
  assign last_addr = (rd_addr + (ADDR_W + 1)'(1)) == n_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    test_ready = 1'b0;
    dp_start   = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        test_ready = 1'b1;
        busy       = 1'b0;
        if (accept) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        dp_start   = 1'b1;
        next_state = (n_q == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN:   if (last_addr) next_state = S_FLUSH;
      S_FLUSH: next_state = S_DRAIN;
      S_DRAIN: next_state = S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Training RAM write port; loading is only allowed while idle.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; its contents survive rst and only the
    // control path around it is cleared.
    if (train_we && (state == S_IDLE)) ram[train_addr] <= {train_label, train_data};
  end

  // Datapath: test latch, read sequencing, candidate register, result capture, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_a     <= '0;
      dp_b     <= '0;
      dp_label <= '0;
      dp_valid <= 1'b0;
      res_info <= '0;
      n_q      <= '0;
      rd_addr  <= '0;
      err      <= 1'b0;
    end else begin
      // The synchronous RAM read lands directly in dp_b/dp_label, so the
      // candidate is valid exactly one cycle after each RUN read.
      dp_valid <= (state == S_RUN);

      if (accept) begin
        dp_a <= test_data;
        if (cfg_n_train > CAPACITY) begin
          n_q <= CAPACITY;
          err <= 1'b1;
        end else begin
          n_q <= cfg_n_train;
        end
      end

      if (train_we && (state != S_IDLE)) err <= 1'b1;

      case (state)
        S_CLEAR: rd_addr <= '0;
        S_RUN: begin
          {dp_label, dp_b} <= ram[rd_addr[ADDR_W-1:0]];
          rd_addr          <= rd_addr + (ADDR_W + 1)'(1);
        end
        S_DRAIN: res_info <= dp_info;
        default: ;
      endcase
    end
  end

`ifdef KNN_SEQ_PERF_EN
  // Per-run cycle counter: starts at 1 on accept, counts while working, frozen in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= 32'd1;
    end else if ((state != S_IDLE) && (state != S_DONE) && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
